// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I encoding constants, ALU operation and core state types
package riscv_pkg;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;
  function automatic alu_op_e alu_op_f(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational RV32I ALU with branch-compare flags
module riscv_alu
  import riscv_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);
  assign eq  = a == b;
  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;
  always_comb begin
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, lt};
      ALU_SLTU: y = {31'b0, ltu};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end
endmodule

// File: rtl/risc_v_core.sv
// risc_v_core: single-cycle RV32I core with private instruction and data memories;
// halts on the first unrecognised instruction word.
module risc_v_core
  import riscv_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 6,
  parameter int OFFSET_BITS  = 3,
  parameter int ADDRESS_BITS = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [19:0]             prog_address,
  input  logic                    isp_write,
  input  logic [ADDRESS_BITS-1:0] isp_address,
  input  logic [DATA_WIDTH-1:0]   isp_data,
  input  logic [1:0]              from_peripheral,
  input  logic [31:0]             from_peripheral_data,
  input  logic                    from_peripheral_valid,
  output logic [1:0]              to_peripheral,
  output logic [31:0]             to_peripheral_data,
  output logic                    to_peripheral_valid,
  input  logic                    report
);
  logic [DATA_WIDTH-1:0] instruction_memory [2**ADDRESS_BITS];
  logic [DATA_WIDTH-1:0] data_memory [2**ADDRESS_BITS];
  logic [DATA_WIDTH-1:0] register_file [32];
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, cycle_q, cycle_d, retired_q, retired_d;
  logic [31:0] instr, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j, pc_4;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  alu_op_e alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic alu_eq, alu_lt, alu_ltu;
  logic legal, rd_we, commit, taken, is_load, is_store, is_link;
  logic [31:0] rd_v, pc_n, dm_rd, dm_wd, dm_mask, ld_v;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [3:0] dm_be;
  logic [ADDRESS_BITS-1:0] dm_idx;
  logic unused_ok;
  assign to_peripheral = '0;
  assign to_peripheral_data = '0;
  assign to_peripheral_valid = 1'b0;
  assign unused_ok = ^{report, from_peripheral, from_peripheral_data, from_peripheral_valid,
                       pc_q[1:0], pc_q[31:ADDRESS_BITS+2], 32'(CORE), 32'(INDEX_BITS), 32'(OFFSET_BITS)};
  assign instr = instruction_memory[pc_q[ADDRESS_BITS+1:2]];
  assign {funct7, rs2, rs1, funct3, rd, opcode} = instr;
  assign rs1_v = rs1 == 5'd0 ? '0 : register_file[rs1];
  assign rs2_v = rs2 == 5'd0 ? '0 : register_file[rs2];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_4 = pc_q + 32'd4;
  assign is_load = opcode == OP_LOAD;
  assign is_store = opcode == OP_STORE;
  assign is_link = opcode == OP_JAL || opcode == OP_JALR;
  always_comb begin
    alu_op = ALU_ADD;
    alu_a = rs1_v;
    alu_b = imm_i;
    legal = 1'b0;
    rd_we = 1'b0;
    case (opcode)
      OP_LUI:    begin legal = 1'b1; rd_we = 1'b1; alu_a = '0; alu_b = imm_u; end
      OP_AUIPC:  begin legal = 1'b1; rd_we = 1'b1; alu_a = pc_q; alu_b = imm_u; end
      OP_JAL:    begin legal = 1'b1; rd_we = 1'b1; end
      OP_JALR:   begin legal = funct3 == 3'd0; rd_we = 1'b1; end
      OP_BRANCH: begin legal = funct3[2:1] != 2'b01; alu_b = rs2_v; end
      OP_LOAD:   begin legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; rd_we = 1'b1; end
      OP_STORE:  begin legal = funct3 < 3'd3; alu_b = imm_s; end
      OP_IMM: begin
        legal = funct3 == F3_SLL ? funct7 == F7_BASE :
                funct3 == F3_SR ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1;
        rd_we = 1'b1;
        alu_op = alu_op_f(funct3, funct3 == F3_SR && funct7[5]);
      end
      OP_REG: begin
        legal = funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
        rd_we = 1'b1;
        alu_b = rs2_v;
        alu_op = alu_op_f(funct3, funct7[5]);
      end
      default: ;
    endcase
  end
  riscv_alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y),
    .eq (alu_eq),
    .lt (alu_lt),
    .ltu(alu_ltu)
  );
  // funct3[0] inverts the base compare: BNE/BGE/BGEU are complements of BEQ/BLT/BLTU
  assign taken = (funct3[2] ? (funct3[1] ? alu_ltu : alu_lt) : alu_eq) ^ funct3[0];
  assign dm_idx = alu_y[ADDRESS_BITS+1:2];
  assign dm_rd = data_memory[dm_idx];
  assign lane_b = 8'(dm_rd >> {alu_y[1:0], 3'b000});
  assign lane_h = 16'(dm_rd >> {alu_y[1], 4'b0000});
  assign ld_v = funct3[1] ? dm_rd :
                funct3[0] ? {{16{~funct3[2] & lane_h[15]}}, lane_h} :
                            {{24{~funct3[2] & lane_b[7]}}, lane_b};
  assign dm_be = !is_store ? 4'b0000 : funct3[1] ? 4'b1111 :
                 funct3[0] ? (alu_y[1] ? 4'b1100 : 4'b0011) : 4'b0001 << alu_y[1:0];
  assign dm_wd = funct3[1] ? rs2_v : funct3[0] ? {2{rs2_v[15:0]}} : {4{rs2_v[7:0]}};
  assign dm_mask = {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}};
  assign rd_v = is_load ? ld_v : is_link ? pc_4 : alu_y;
  assign pc_n = opcode == OP_JAL ? pc_q + imm_j :
                opcode == OP_JALR ? {alu_y[31:1], 1'b0} :
                opcode == OP_BRANCH && taken ? pc_q + imm_b : pc_4;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    commit = 1'b0;
    if (start) begin
      state_d = S_RUN;
      pc_d = {12'b0, prog_address};
    end else if (state_q == S_RUN) begin
      commit = legal && reset;
      pc_d = legal ? pc_n : pc_q;
      state_d = legal ? S_RUN : S_HALT;
    end
    cycle_d = cycle_q + {31'b0, state_q == S_RUN};
    retired_d = retired_q + {31'b0, commit};
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      cycle_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cycle_q <= cycle_d;
      retired_q <= retired_d;
    end
  end
  // Architectural storage is deliberately outside reset so state survives for inspection
  always_ff @(posedge clock) begin
    if (isp_write) instruction_memory[isp_address] <= isp_data;
    if (commit && rd_we && rd != 5'd0) register_file[rd] <= rd_v;
    if (commit && |dm_be) data_memory[dm_idx] <= (dm_rd & ~dm_mask) | (dm_wd & dm_mask);
  end
endmodule

// File: tb/tb_risc_v_core.sv
// tb_risc_v_core: directed programs plus a random ALU program checked against a reference model.
module tb_risc_v_core;
  import riscv_pkg::*;
  logic clock = 0, reset = 0, start = 0, isp_write = 0, report = 0;
  logic [19:0] prog_address = '0;
  logic [11:0] isp_address = '0;
  logic [31:0] isp_data = '0;
  logic [1:0] from_peripheral = '0, to_peripheral;
  logic [31:0] from_peripheral_data = '0, to_peripheral_data;
  logic from_peripheral_valid = 0, to_peripheral_valid;
  int n_checks = 0, n_fail = 0;
  logic [31:0] m [32];
  logic [31:0] prog [$];
  int f3_tab [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int imap [9] = '{0, 3, 4, 5, 8, 9, 2, 6, 7};
  int k, base;
  logic [4:0] rd, rs1, rs2;
  logic [11:0] r12;
  logic [19:0] u20;
  logic [31:0] imm, res;

  risc_v_core dut (
    .clock(clock), .reset(reset), .start(start), .prog_address(prog_address),
    .isp_write(isp_write), .isp_address(isp_address), .isp_data(isp_data),
    .from_peripheral(from_peripheral), .from_peripheral_data(from_peripheral_data),
    .from_peripheral_valid(from_peripheral_valid), .to_peripheral(to_peripheral),
    .to_peripheral_data(to_peripheral_data), .to_peripheral_valid(to_peripheral_valid),
    .report(report)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_prog(input int base_word, input logic [31:0] words [$]);
    foreach (words[i]) begin
      isp_write = 1; isp_address = 12'(base_word + i); isp_data = words[i];
      tick();
    end
    isp_write = 0;
  endtask

  task automatic pulse_start(input logic [19:0] a);
    start = 1; prog_address = a;
    tick();
    start = 0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int c = 0;
    while (dut.state_q != S_HALT && c < budget) begin tick(); c++; end
    check({tag, " reached HALT"}, 32'(dut.state_q), 32'(S_HALT));
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] i, input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {i[11:0], s1, f3, d, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] d, input logic [4:0] s1, input logic [31:0] i);
    return enc_i(i, s1, 3'd0, d, 7'h13);
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] d, input logic [19:0] i);
    return {i, d, 7'h37};
  endfunction
  function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] o);
    return {o[12], o[10:5], s2, s1, f3, o[4:1], o[11], 7'h63};
  endfunction
  function automatic logic [31:0] ld(input logic [2:0] f3, input logic [4:0] d, input logic [31:0] a);
    return enc_i(a, 5'd0, f3, d, 7'h03);
  endfunction
  function automatic logic [31:0] st(input logic [2:0] f3, input logic [4:0] s2, input logic [31:0] a);
    return {a[11:5], s2, 5'd0, f3, a[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] jal(input logic [4:0] d, input logic [31:0] o);
    return {o[20], o[10:1], o[11], o[19:12], d, 7'h6f};
  endfunction

  // Spec-level meaning of each base integer operation, indexed by a bench-local code
  function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return $signed(a) >>> b[4:0];
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  initial begin
    tick(5);
    check("reset state", 32'(dut.state_q), 32'(S_IDLE));
    check("reset pc", dut.pc_q, 32'h0);
    check("reset retired", dut.retired_q, 32'h0);
    check("reset cycles", dut.cycle_q, 32'h0);
    isp_write = 1; isp_address = '0; isp_data = '0;
    tick();
    isp_write = 0;
    reset = 1;
    tick();
    pulse_start(20'h0);
    check("start enters RUN", 32'(dut.state_q), 32'(S_RUN));
    tick();
    check("empty halts", 32'(dut.state_q), 32'(S_HALT));
    check("empty retired", dut.retired_q, 32'h0);
    check("empty pc holds", dut.pc_q, 32'h0);
    check("empty x11", dut.register_file[11], 32'h0);
    check("periph out", {to_peripheral_valid, to_peripheral, to_peripheral_data[28:0]}, 32'h0);

    prog = {};
    prog.push_back(addi(5, 0, 0));
    prog.push_back(lui(11, 20'h00001));
    prog.push_back(lui(12, 20'h80000));
    prog.push_back(lui(13, 20'hfffff));
    prog.push_back(addi(14, 13, 0));
    prog.push_back(br(3'd7, 13, 11, 8));
    prog.push_back(addi(16, 0, 1));
    prog.push_back(br(3'd7, 11, 12, 8));
    prog.push_back(addi(16, 11, 1));
    prog.push_back(addi(15, 12, 0));
    prog.push_back(br(3'd4, 12, 11, 8));
    prog.push_back(addi(5, 5, 100));
    prog.push_back(addi(5, 5, 1));
    prog.push_back(br(3'd6, 12, 11, 8));
    prog.push_back(addi(5, 5, 2));
    prog.push_back(br(3'd5, 11, 12, 8));
    prog.push_back(addi(5, 5, 16));
    prog.push_back(jal(1, 8));
    prog.push_back(addi(5, 5, 64));
    prog.push_back(lui(6, 20'hdeadc));
    prog.push_back(addi(6, 6, -32'sh111));
    prog.push_back(st(3'd2, 6, 16));
    prog.push_back(ld(3'd0, 7, 19));
    prog.push_back(ld(3'd4, 8, 19));
    prog.push_back(st(3'd1, 6, 34));
    prog.push_back(ld(3'd1, 20, 34));
    prog.push_back(ld(3'd5, 21, 34));
    prog.push_back(ld(3'd2, 22, 16));
    prog.push_back({20'h00001, 5'd23, 7'h17});
    prog.push_back(enc_i(prog.size() * 4 + 9, 0, 3'd0, 24, 7'h67));
    prog.push_back(addi(5, 5, 256));
    prog.push_back(br(3'd1, 7, 8, 8));
    prog.push_back(addi(5, 5, 32));
    prog.push_back(br(3'd0, 14, 13, 8));
    prog.push_back(addi(5, 5, 128));
    prog.push_back(addi(27, 0, 9));
    prog.push_back(addi(0, 0, 5));
    prog.push_back({7'h00, 5'd0, 5'd0, 3'd0, 5'd27, 7'h33});
    prog.push_back(32'h0);
    write_prog(0, prog);
    pulse_start(20'h0);
    run_to_halt("progA", 200);
    check("a1", dut.register_file[11], 32'h00001000);
    check("a2", dut.register_file[12], 32'h80000000);
    check("a3", dut.register_file[13], 32'hfffff000);
    check("a4", dut.register_file[14], 32'hfffff000);
    check("a5", dut.register_file[15], 32'h80000000);
    check("a6", dut.register_file[16], 32'h00001001);
    check("a0", dut.register_file[10], 32'h0);
    check("a7", dut.register_file[17], 32'h0);
    check("branch path x5", dut.register_file[5], 32'd3);
    check("jal link", dut.register_file[1], 32'd72);
    check("lui+addi", dut.register_file[6], 32'hdeadbeef);
    check("lb", dut.register_file[7], 32'hffffffde);
    check("lbu", dut.register_file[8], 32'h000000de);
    check("lh", dut.register_file[20], 32'hffffbeef);
    check("lhu", dut.register_file[21], 32'h0000beef);
    check("lw", dut.register_file[22], 32'hdeadbeef);
    check("auipc", dut.register_file[23], 32'h00001070);
    check("jalr link", dut.register_file[24], 32'd120);
    check("x0 discard", dut.register_file[27], 32'h0);
    check("progA halt pc", dut.pc_q, 32'd152);
    check("progA retired", dut.retired_q, 32'd31);
    check("progA cycles", dut.cycle_q, 32'd33);

    prog = {};
    m[0] = '0;
    for (int r = 1; r < 32; r++) begin
      u20 = 20'($urandom); r12 = 12'($urandom);
      prog.push_back(lui(5'(r), u20));
      prog.push_back(addi(5'(r), 5'(r), {{20{r12[11]}}, r12}));
      m[r] = {u20, 12'b0} + {{20{r12[11]}}, r12};
    end
    for (int n = 0; n < 50; n++) begin
      k = int'($urandom_range(0, 18));
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      if (k < 10) begin
        base = k;
        prog.push_back({(base == 1 || base == 7) ? 7'h20 : 7'h00, rs2, rs1, 3'(f3_tab[base]), rd, 7'h33});
        res = ref_op(base, m[rs1], m[rs2]);
      end else begin
        base = imap[k - 10];
        r12 = 12'($urandom);
        if (base == 2 || base == 6 || base == 7) r12 = {base == 7 ? 7'h20 : 7'h00, r12[4:0]};
        imm = {{20{r12[11]}}, r12};
        prog.push_back({r12, rs1, 3'(f3_tab[base]), rd, 7'h13});
        res = ref_op(base, m[rs1], imm);
      end
      if (rd != 0) m[rd] = res;
    end
    prog.push_back(32'h0);
    write_prog(256, prog);
    pulse_start(20'h400);
    run_to_halt("random", 400);
    for (int r = 1; r < 32; r++) check($sformatf("random x%0d", r), dut.register_file[r], m[r]);
    check("random halt pc", dut.pc_q, 32'h400 + 32'(4 * (prog.size() - 1)));
    check("random retired", dut.retired_q, 32'd143);

    prog = {};
    prog.push_back(addi(22, 0, 0));
    prog.push_back(addi(22, 22, 1));
    prog.push_back(jal(0, -4));
    write_prog(128, prog);
    pulse_start(20'h200);
    tick(9);
    check("loop x22", dut.register_file[22], 32'd4);
    check("loop retired", dut.retired_q, 32'd152);
    reset = 0;
    tick(3);
    check("midrun reset state", 32'(dut.state_q), 32'(S_IDLE));
    check("midrun reset pc", dut.pc_q, 32'h0);
    check("midrun reset retired", dut.retired_q, 32'h0);
    check("regs kept", dut.register_file[22], 32'd4);
    reset = 1;
    pulse_start(20'h204);
    tick(4);
    check("resume x22", dut.register_file[22], 32'd6);
    check("resume retired", dut.retired_q, 32'd4);
    check("resume cycles", dut.cycle_q, 32'd4);
    check("resume pc", dut.pc_q, 32'h204);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
